// File: rtl/load_store_unit_if.sv
// Load/store unit bus interface.
// Bundles three groups of signals:
//   - request handshake from the execute stage (req_*)
//   - one-cycle completion pulse (resp_*)
//   - data memory port (mem_*)
// Modports:
//   slave  : the load/store unit's view
//   master : the surrounding environment (execute stage plus data memory)
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [63:0] mem_read_data;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misaligned,
        output mem_address, mem_write_data, mem_write_en, mem_read_en,
        input  mem_read_data
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misaligned,
        input  mem_address, mem_write_data, mem_write_en, mem_read_en,
        output mem_read_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit.
// Accepts one load or store at a time from the execute stage and performs
// it against a 64-bit data memory with combinational read data.
// Sub-doubleword stores are done as read-modify-write. Loads are sign- or
// zero-extended. Misaligned requests can optionally be trapped without
// touching memory.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : load_store_unit_if.slave (request, response and memory port)
// Parameters:
//   CHECK_ALIGN : 1 = trap misaligned requests, 0 = no alignment check
module load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    // Request fields latched on accept
    logic        store_reg;
    logic        uns_reg;
    logic        mis_reg;
    logic [1:0]  size_reg;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    // Memory data captured at the end of the READ cycle
    logic [63:0] data_reg;

    logic        req_ready;
    logic        resp_valid;
    logic        resp_misaligned;
    logic [63:0] resp_rdata;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;

    logic        misaligned_in;
    logic [7:0]  byte_mask;
    logic [63:0] merged_data;
    logic [63:0] load_ext;

    // addr mod 2^size != 0, evaluated on the incoming request
    always_comb begin
        misaligned_in = 1'b0;
        case (bus.req_size)
            2'b00:   misaligned_in = 1'b0;
            2'b01:   misaligned_in = bus.req_addr[0];
            2'b10:   misaligned_in = |bus.req_addr[1:0];
            default: misaligned_in = |bus.req_addr[2:0];
        endcase
        misaligned_in = misaligned_in && CHECK_ALIGN;
    end

    // Byte lanes covered by the access size; lanes outside keep the
    // captured memory data during read-modify-write.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign byte_mask[gi] = (4'(gi) < (4'd1 << size_reg));
            assign merged_data[8*gi +: 8] = byte_mask[gi] ? wdata_reg[8*gi +: 8]
                                                          : data_reg[8*gi +: 8];
        end
    endgenerate

    // Sign/zero extension of the captured load data
    always_comb begin
        load_ext = data_reg;
        case (size_reg)
            2'b00: load_ext = {{56{!uns_reg && data_reg[7]}},  data_reg[7:0]};
            2'b01: load_ext = {{48{!uns_reg && data_reg[15]}}, data_reg[15:0]};
            2'b10: load_ext = {{32{!uns_reg && data_reg[31]}}, data_reg[31:0]};
            default: load_ext = data_reg;
        endcase
    end

    // State register and request/data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            store_reg <= 1'b0;
            uns_reg   <= 1'b0;
            mis_reg   <= 1'b0;
            size_reg  <= 2'b00;
            addr_reg  <= 64'd0;
            wdata_reg <= 64'd0;
            data_reg  <= 64'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.req_valid) begin
                store_reg <= bus.req_store;
                uns_reg   <= bus.req_unsigned;
                mis_reg   <= misaligned_in;
                size_reg  <= bus.req_size;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
            end
            if (state_reg == READ) begin
                data_reg <= bus.mem_read_data;
            end
        end
    end

    // Next state and outputs. Every output is forced low while rst is high,
    // which also drops a write that is in flight when reset arrives.
    always_comb begin
        state_next      = state_reg;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_misaligned = 1'b0;
        resp_rdata      = 64'd0;
        mem_address     = 64'd0;
        mem_write_data  = 64'd0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    req_ready = 1'b1;
                    if (bus.req_valid) begin
                        if (misaligned_in)
                            state_next = RESP;
                        else if (bus.req_store && bus.req_size == 2'b11)
                            state_next = WRITE;
                        else
                            state_next = READ;
                    end
                end
                READ: begin
                    mem_read_en = 1'b1;
                    mem_address = addr_reg;
                    state_next  = store_reg ? WRITE : RESP;
                end
                WRITE: begin
                    mem_write_en   = 1'b1;
                    mem_address    = addr_reg;
                    mem_write_data = (size_reg == 2'b11) ? wdata_reg : merged_data;
                    state_next     = RESP;
                end
                default: begin
                    resp_valid      = 1'b1;
                    resp_misaligned = mis_reg;
                    resp_rdata      = (store_reg || mis_reg) ? 64'd0 : load_ext;
                    state_next      = IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready;
    assign bus.resp_valid      = resp_valid;
    assign bus.resp_misaligned = resp_misaligned;
    assign bus.resp_rdata      = resp_rdata;
    assign bus.mem_address     = mem_address;
    assign bus.mem_write_data  = mem_write_data;
    assign bus.mem_write_en    = mem_write_en;
    assign bus.mem_read_en     = mem_read_en;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter CHECK_ALIGN, default 1, meaning a misaligned request is trapped with no memory access (0 = no alignment check).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request from execute stage.
REQ-006 req_ready  out  1  unit can accept a request.
REQ-007 req_store  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 double.
REQ-009 req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_addr  in  64  byte address.
REQ-011 req_wdata  in  64  store data; low size bytes used.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  64  extended load data.
REQ-014 resp_misaligned  out  1  request was trapped.
REQ-015 mem_address  out  64  data memory byte address.
REQ-016 mem_write_data  out  64  data memory write data; byte n goes to address+n.
REQ-017 mem_write_en  out  1  data memory write strobe; memory writes on the clk edge.
REQ-018 mem_read_en  out  1  data memory read enable.
REQ-019 mem_read_data  in  64  combinational memory read data; byte n is from address+n.

Function
REQ-020 SHALL implement an FSM with states IDLE, READ, WRITE and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted on a clk edge where req_valid && req_ready.
REQ-022 On accept, store, size, unsigned, addr and wdata SHALL be latched; later changes on req_* are ignored until RESP completes.
REQ-023 Accept, misaligned (addr mod 2^size != 0) with CHECK_ALIGN=1 -> RESP with resp_misaligned=1 and no mem_read_en or mem_write_en in any cycle.
REQ-024 Accept, store with size 11 -> WRITE.
REQ-025 Accept, all other requests -> READ.
REQ-026 READ: mem_read_en=1, mem_address=latched addr; mem_read_data is registered at the end of the cycle.
REQ-027 READ, load -> RESP.
REQ-028 READ, store -> WRITE.
REQ-029 WRITE: mem_write_en=1, mem_address=latched addr.
REQ-030 WRITE, size 11: mem_write_data SHALL be the latched wdata.
REQ-031 WRITE, sub-doubleword: mem_write_data SHALL be the captured read data with its low 2^size bytes replaced by the low bytes of wdata (read-modify-write).
REQ-032 WRITE -> RESP.
REQ-033 RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
REQ-034 resp_rdata SHALL be the low 2^size bytes of captured data, sign- or zero-extended to 64; for size 11 no extension.
REQ-035 resp_rdata SHALL be 0 for stores and misaligned requests.
REQ-036 resp_misaligned SHALL be 0 in any cycle where resp_valid=0.
REQ-037 Latency, accept edge to resp_valid: loads 2 cycles; double stores 2 cycles; sub-doubleword stores 3 cycles; misaligned 1 cycle.
REQ-038 Throughput SHALL be one request per latency+1 cycles; resp has no backpressure.
REQ-039 In cycles outside READ and WRITE, mem_read_en, mem_write_en, mem_address and mem_write_data SHALL be 0.
REQ-040 Address arithmetic SHALL be 64-bit; there is no wrap check (0xFFFF_FFFF_FFFF_FFF8 is passed unchanged).

Reset
REQ-041 An edge with rst=1 SHALL force state IDLE and clear all latched and captured registers.
REQ-042 While rst=1, req_ready, resp_valid, resp_misaligned, resp_rdata and all mem_* outputs SHALL be 0; mem_write_en is gated by !rst so that an in-flight write is dropped.
REQ-043 The first cycle after rst deasserts SHALL have req_ready=1.

Verification
REQ-044 Load byte: memory 0x10..0x17 = 80,81..87; byte load, signed, at 0x10 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80 two cycles after accept; the unsigned form returns 0x80.
REQ-045 Load word: unsigned word load at 0x14 -> resp_rdata=0x0000_0000_8786_8584; mem_read_en high for exactly one cycle.
REQ-046 Store half: 0x1234 at 0x12 (0x18,0x19 = 0) -> READ, then WRITE with mem_write_data=0x0000_8786_8584_1234 and resp_valid 3 cycles after accept; a following double load at 0x10 -> 0x8786_8584_1234_8180.
REQ-047 Misaligned: word load at 0x13 -> resp_valid and resp_misaligned 1 cycle after accept, resp_rdata=0, mem_read_en and mem_write_en never asserted.
REQ-048 Reset: rst asserted during the WRITE cycle of a word store -> mem_write_en=0 and memory unchanged; req_ready=1 in the cycle after rst drops.
REQ-049 Back-to-back: req_valid held high with two loads -> second accepted only on the edge after RESP (3-cycle spacing), and both responses are correct.
